// File: rtl/xalu_ise_mc.sv
// Multi-cycle Xoodyak custom-1 ALU: single-cycle xorrol and iterative per-lane rolv
// over XLEN/32 independent 32-bit Xoodoo lanes, with valid/ready on both sides.
module xalu_ise_mc #(
    parameter int XLEN  = 32,
    parameter int ROT_A = 5,
    parameter int ROT_B = 14,
    parameter int SPC   = 1
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic [4:0]      ise_fn,
    input  logic [6:0]      ise_imm,
    input  logic [XLEN-1:0] ise_in1,
    input  logic [XLEN-1:0] ise_in2,
    input  logic            ise_val,
    output logic            ise_rdy,
    output logic            ise_oval,
    input  logic            ise_ordy,
    output logic [XLEN-1:0] ise_out
);

    localparam int L = XLEN / 32;
    localparam int N = (5 + SPC - 1) / SPC;

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [XLEN-1:0]   work;
    logic [5*L-1:0]    amt_q;
    logic [XLEN-1:0]   out_q;
    logic              oval_q;

    logic              sel_x, sel_r, accept;
    logic [5*L-1:0]    amt_in;
    logic [XLEN-1:0]   first_step, rot_next;
    logic              unused_fn;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int sh);
        rotl32 = (sh == 0) ? v : ((v << sh) | (v >> (32 - sh)));
    endfunction

    function automatic logic [XLEN-1:0] xorrol(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++)
            r[32*i +: 32] = rotl32(a[32*i +: 32], ROT_A) ^ rotl32(b[32*i +: 32], ROT_B);
        return r;
    endfunction

    // Applies up to SPC log-rotator stages starting at stage `start`; stages past 4 are skipped.
    function automatic logic [XLEN-1:0] rot_step(input logic [XLEN-1:0] v,
                                                 input logic [5*L-1:0] amt,
                                                 input logic [2:0]     start);
        logic [XLEN-1:0] r;
        logic [31:0]     lane;
        int              k;
        r = '0;
        for (int i = 0; i < L; i++) begin
            lane = v[32*i +: 32];
            for (int j = 0; j < SPC; j++) begin
                k = int'(start) + j;
                if (k < 5) begin
                    if (amt[5*i + k])
                        lane = rotl32(lane, 1 << k);
                end
            end
            r[32*i +: 32] = lane;
        end
        return r;
    endfunction

    always_comb begin
        amt_in = '0;
        for (int i = 0; i < L; i++)
            amt_in[5*i +: 5] = ise_in2[32*i +: 5];
    end

    assign sel_x      = (ise_imm == 7'b0100000) && (ise_fn[1:0] == 2'b01);
    assign sel_r      = (ise_imm == 7'b0100001) && (ise_fn[1:0] == 2'b01);
    assign unused_fn  = ^ise_fn[4:2];

    // NOTE: ready is combinational on ise_ordy in DONE so a consumed result and a
    // new request can share one edge; every other output comes straight from a flop.
    assign ise_rdy    = (state == IDLE) || ((state == DONE) && ise_ordy);
    assign accept     = ise_val && ise_rdy && (sel_x || sel_r);

    assign first_step = rot_step(ise_in1, amt_in, 3'd0);
    assign rot_next   = rot_step(work, amt_q, cnt);

    assign ise_oval   = oval_q;
    assign ise_out    = out_q;

    // NOTE: operand and working registers are reset too, so an op aborted by
    // reset leaves nothing behind that could leak into a later result.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            work   <= '0;
            amt_q  <= '0;
            out_q  <= '0;
            oval_q <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            if (sel_x) begin
                out_q  <= xorrol(ise_in1, ise_in2);
                oval_q <= 1'b1;
                state  <= DONE;
            end else begin
                work  <= first_step;
                amt_q <= amt_in;
                if (N == 1) begin
                    out_q  <= first_step;
                    oval_q <= 1'b1;
                    state  <= DONE;
                end else begin
                    out_q  <= '0;
                    oval_q <= 1'b0;
                    cnt    <= 3'(SPC);
                    state  <= ROT;
                end
            end
        end else begin
            case (state)
                ROT: begin
                    work <= rot_next;
                    if (int'(cnt) + SPC >= 5) begin
                        out_q  <= rot_next;
                        oval_q <= 1'b1;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 3'(SPC);
                    end
                end
                DONE: begin
                    if (ise_ordy) begin
                        out_q  <= '0;
                        oval_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
